// File: rtl/hpdmc_ddr_wrpath.sv
// hpdmc_ddr_wrpath
// Write-path sequencer for the DDR16 SDRAM controller. It feeds the per-pin
// DDR output registers for DQ, DM and DQS. Each host word is split into a
// rising-edge half (D0, upper bits) and a falling-edge half (D1, lower bits).
// The block also produces the DQS preamble, toggle and postamble, and the pad
// output enables. The 90-degree DQS shift is done by the output-register
// clocking, outside this block.
//
// Ports:
//   sys_clk, sys_rst_n  : clock, synchronous active-low reset
//   wr_start            : one-cycle burst request (ignored while busy)
//   busy                : high whenever the sequencer is not idle
//   wr_ack              : wr_data/wr_mask are consumed on this cycle's edge
//   wr_data, wr_mask    : host word and byte masks (1 = masked)
//   dq_d0/dq_d1         : rising/falling-edge DQ data
//   dm_d0/dm_d1         : rising/falling-edge DM
//   dqs_d0/dqs_d1       : rising/falling-edge DQS value
//   dq_oe, dqs_oe       : pad output enables, active high
module hpdmc_ddr_wrpath #(
   parameter int DQ_WIDTH     = 16,
   parameter int BURST_CYCLES = 4,
   parameter int PRE_DELAY    = 0
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic                    wr_start,
   output logic                    busy,
   output logic                    wr_ack,
   input  logic [2*DQ_WIDTH-1:0]   wr_data,
   input  logic [DQ_WIDTH/4-1:0]   wr_mask,
   output logic [DQ_WIDTH-1:0]     dq_d0,
   output logic [DQ_WIDTH-1:0]     dq_d1,
   output logic [DQ_WIDTH/8-1:0]   dm_d0,
   output logic [DQ_WIDTH/8-1:0]   dm_d1,
   output logic                    dqs_d0,
   output logic                    dqs_d1,
   output logic                    dq_oe,
   output logic                    dqs_oe
);

   localparam int DM_W   = DQ_WIDTH / 8;
   localparam int MASK_W = DQ_WIDTH / 4;
   localparam logic [3:0] BURST_LAST = 4'(BURST_CYCLES);
   localparam logic [2:0] WAIT_INIT  = 3'(PRE_DELAY);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_PRE,
      S_DATA,
      S_POST
   } state_t;

   state_t      state;
   logic [3:0]  beat;
   logic [2:0]  wait_cnt;

   // Every output is registered, so each branch computes the values that
   // belong to the state being entered. wr_ack is raised one cycle ahead of
   // each DATA cycle: the word the host presents while wr_ack is high is
   // captured on that edge and shows up on dq_d0/dq_d1 in the next cycle.
   // dqs_d1 is always low: DQS toggles once per cycle as 1 then 0 in DATA.
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state    <= S_IDLE;
         beat     <= '0;
         wait_cnt <= '0;
         busy     <= 1'b0;
         wr_ack   <= 1'b0;
         dq_d0    <= '0;
         dq_d1    <= '0;
         dm_d0    <= '1;
         dm_d1    <= '1;
         dqs_d0   <= 1'b0;
         dqs_d1   <= 1'b0;
         dq_oe    <= 1'b0;
         dqs_oe   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (wr_start) begin
                  busy <= 1'b1;
                  if (PRE_DELAY > 0) begin
                     state    <= S_WAIT;
                     wait_cnt <= WAIT_INIT;
                  end else begin
                     state  <= S_PRE;
                     wr_ack <= 1'b1;
                     dqs_oe <= 1'b1;
                  end
               end
            end

            // The counter is loaded with PRE_DELAY on entry, so leaving when
            // it reads 1 gives exactly PRE_DELAY cycles in WAIT.
            S_WAIT: begin
               if (wait_cnt == 3'd1) begin
                  state    <= S_PRE;
                  wait_cnt <= '0;
                  wr_ack   <= 1'b1;
                  dqs_oe   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end

            S_PRE: begin
               state  <= S_DATA;
               beat   <= 4'd1;
               dq_oe  <= 1'b1;
               dqs_d0 <= 1'b1;
               dq_d0  <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
               dq_d1  <= wr_data[DQ_WIDTH-1:0];
               dm_d0  <= wr_mask[MASK_W-1:DM_W];
               dm_d1  <= wr_mask[DM_W-1:0];
               wr_ack <= (BURST_LAST > 4'd1);
            end

            // beat counts DATA cycles already entered, including the
            // current one; the last beat hands over to the postamble.
            S_DATA: begin
               if (beat == BURST_LAST) begin
                  state  <= S_POST;
                  beat   <= '0;
                  dq_oe  <= 1'b0;
                  dqs_d0 <= 1'b0;
                  dm_d0  <= '1;
                  dm_d1  <= '1;
                  wr_ack <= 1'b0;
               end else begin
                  beat   <= beat + 4'd1;
                  dq_d0  <= wr_data[2*DQ_WIDTH-1:DQ_WIDTH];
                  dq_d1  <= wr_data[DQ_WIDTH-1:0];
                  dm_d0  <= wr_mask[MASK_W-1:DM_W];
                  dm_d1  <= wr_mask[DM_W-1:0];
                  wr_ack <= (beat + 4'd1 < BURST_LAST);
               end
            end

            S_POST: begin
               state  <= S_IDLE;
               busy   <= 1'b0;
               dqs_oe <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hpdmc_ddr_wrpath.sv
// tb_hpdmc_ddr_wrpath
// Directed bench for hpdmc_ddr_wrpath. Instance A uses default parameters;
// instance B uses PRE_DELAY=3, BURST_CYCLES=2. Both share clock and reset.
module tb_hpdmc_ddr_wrpath;

   logic        clk;
   logic        rstN;

   logic        startA, busyA, wrAckA, dqsD0A, dqsD1A, dqOeA, dqsOeA;
   logic [31:0] dataA;
   logic [3:0]  maskA;
   logic [15:0] dqD0A, dqD1A;
   logic [1:0]  dmD0A, dmD1A;

   logic        startB, busyB, wrAckB, dqsD0B, dqsD1B, dqOeB, dqsOeB;
   logic [31:0] dataB;
   logic [3:0]  maskB;
   logic [15:0] dqD0B, dqD1B;
   logic [1:0]  dmD0B, dmD1B;

   int errors = 0;
   int checks = 0;
   int ackCountA = 0;
   int dqsCountA = 0;

   logic [31:0] wordTab [4];
   logic [15:0] expHi   [4];
   logic [15:0] expLo   [4];
   logic [3:0]  maskTab [4];
   logic [1:0]  expDm0  [4];
   logic [1:0]  expDm1  [4];

   hpdmc_ddr_wrpath dutA (
      .sys_clk   (clk),
      .sys_rst_n (rstN),
      .wr_start  (startA),
      .busy      (busyA),
      .wr_ack    (wrAckA),
      .wr_data   (dataA),
      .wr_mask   (maskA),
      .dq_d0     (dqD0A),
      .dq_d1     (dqD1A),
      .dm_d0     (dmD0A),
      .dm_d1     (dmD1A),
      .dqs_d0    (dqsD0A),
      .dqs_d1    (dqsD1A),
      .dq_oe     (dqOeA),
      .dqs_oe    (dqsOeA)
   );

   hpdmc_ddr_wrpath #(
      .DQ_WIDTH     (16),
      .BURST_CYCLES (2),
      .PRE_DELAY    (3)
   ) dutB (
      .sys_clk   (clk),
      .sys_rst_n (rstN),
      .wr_start  (startB),
      .busy      (busyB),
      .wr_ack    (wrAckB),
      .wr_data   (dataB),
      .wr_mask   (maskB),
      .dq_d0     (dqD0B),
      .dq_d1     (dqD1B),
      .dm_d0     (dmD0B),
      .dm_d1     (dmD1B),
      .dqs_d0    (dqsD0B),
      .dqs_d1    (dqsD1B),
      .dq_oe     (dqOeB),
      .dqs_oe    (dqsOeB)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge and sample 1 ns later; tallies instance A activity.
   task automatic applyStimulus();
      @(posedge clk);
      #1;
      if (wrAckA) ackCountA++;
      if (dqsOeA) dqsCountA++;
   endtask

   // Full default burst on instance A, started from IDLE. When dropStart is
   // set, a second wr_start is presented at T+3 and must be ignored.
   task automatic burstA(input bit dropStart);
      ackCountA = 0;
      dqsCountA = 0;
      startA = 1'b1;
      applyStimulus();
      checkOutput("pre_ack",   {31'd0, wrAckA}, 32'd1);
      checkOutput("pre_dqsoe", {31'd0, dqsOeA}, 32'd1);
      checkOutput("pre_dqoe",  {31'd0, dqOeA},  32'd0);
      checkOutput("pre_dqs0",  {31'd0, dqsD0A}, 32'd0);
      checkOutput("pre_busy",  {31'd0, busyA},  32'd1);
      startA = 1'b0;
      for (int i = 0; i < 4; i++) begin
         dataA  = wordTab[i];
         maskA  = maskTab[i];
         startA = dropStart && (i == 2);
         applyStimulus();
         checkOutput($sformatf("d0_%0d", i), {16'd0, dqD0A}, {16'd0, expHi[i]});
         checkOutput($sformatf("d1_%0d", i), {16'd0, dqD1A}, {16'd0, expLo[i]});
         checkOutput($sformatf("dm0_%0d", i), {30'd0, dmD0A}, {30'd0, expDm0[i]});
         checkOutput($sformatf("dm1_%0d", i), {30'd0, dmD1A}, {30'd0, expDm1[i]});
         checkOutput($sformatf("dqoe_%0d", i), {31'd0, dqOeA}, 32'd1);
         checkOutput($sformatf("dqs_%0d", i), {30'd0, dqsD0A, dqsD1A}, 32'd2);
         checkOutput($sformatf("ack_%0d", i), {31'd0, wrAckA}, (i < 3) ? 32'd1 : 32'd0);
      end
      startA = 1'b0;
      dataA  = 32'hDEADBEEF;
      maskA  = 4'b0000;
      applyStimulus();
      checkOutput("post_dqsoe", {31'd0, dqsOeA}, 32'd1);
      checkOutput("post_dqoe",  {31'd0, dqOeA},  32'd0);
      checkOutput("post_dqs",   {30'd0, dqsD0A, dqsD1A}, 32'd0);
      checkOutput("post_dm",    {28'd0, dmD0A, dmD1A}, 32'hF);
      checkOutput("post_hold",  {dqD0A, dqD1A}, 32'h01020304);
      checkOutput("post_busy",  {31'd0, busyA}, 32'd1);
      applyStimulus();
      checkOutput("idle_busy",  {31'd0, busyA},  32'd0);
      checkOutput("idle_dqsoe", {31'd0, dqsOeA}, 32'd0);
      for (int i = 0; i < 3; i++) applyStimulus();
      checkOutput("after_busy", {31'd0, busyA}, 32'd0);
      checkOutput("ack_pulses", ackCountA, 32'd4);
      checkOutput("dqsoe_cycles", dqsCountA, 32'd6);
   endtask

   initial begin
      wordTab = '{32'hA1A2B1B2, 32'hC1C2D1D2, 32'hE1E2F1F2, 32'h01020304};
      expHi   = '{16'hA1A2, 16'hC1C2, 16'hE1E2, 16'h0102};
      expLo   = '{16'hB1B2, 16'hD1D2, 16'hF1F2, 16'h0304};
      maskTab = '{4'b0000, 4'b1001, 4'b0000, 4'b0000};
      expDm0  = '{2'b00, 2'b10, 2'b00, 2'b00};
      expDm1  = '{2'b00, 2'b01, 2'b00, 2'b00};

      rstN   = 1'b0;
      startA = 1'b1;
      startB = 1'b1;
      dataA  = '0;
      maskA  = '0;
      dataB  = '0;
      maskB  = '0;

      // Reset held for three edges with wr_start asserted.
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput($sformatf("rst_busy_%0d", i), {31'd0, busyA}, 32'd0);
         checkOutput($sformatf("rst_oe_%0d", i), {30'd0, dqOeA, dqsOeA}, 32'd0);
         checkOutput($sformatf("rst_dm_%0d", i), {28'd0, dmD0A, dmD1A}, 32'hF);
         checkOutput($sformatf("rst_ack_%0d", i), {31'd0, wrAckA}, 32'd0);
         checkOutput($sformatf("rst_busyB_%0d", i), {31'd0, busyB}, 32'd0);
      end
      checkOutput("rst_dq", {dqD0A, dqD1A}, 32'd0);
      startA = 1'b0;
      startB = 1'b0;
      rstN   = 1'b1;
      applyStimulus();
      checkOutput("rst_release_busy", {31'd0, busyA}, 32'd0);

      // Default burst with masking on word 1 and a dropped wr_start.
      burstA(1'b1);

      // PRE_DELAY=3, BURST_CYCLES=2 on instance B.
      startB = 1'b1;
      applyStimulus();
      startB = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         checkOutput($sformatf("B_wait_busy_%0d", i), {31'd0, busyB}, 32'd1);
         checkOutput($sformatf("B_wait_oe_%0d", i), {30'd0, dqOeB, dqsOeB}, 32'd0);
         checkOutput($sformatf("B_wait_ack_%0d", i), {31'd0, wrAckB}, 32'd0);
         if (i < 3) applyStimulus();
      end
      applyStimulus();
      checkOutput("B_pre_dqsoe", {31'd0, dqsOeB}, 32'd1);
      checkOutput("B_pre_dqoe",  {31'd0, dqOeB},  32'd0);
      checkOutput("B_pre_ack",   {31'd0, wrAckB}, 32'd1);
      dataB = 32'h11223344;
      maskB = 4'b0110;
      applyStimulus();
      checkOutput("B_d0_word", {dqD0B, dqD1B}, 32'h11223344);
      checkOutput("B_d0_dm",   {28'd0, dmD0B, dmD1B}, 32'h6);
      checkOutput("B_d0_ack",  {31'd0, wrAckB}, 32'd1);
      checkOutput("B_d0_dqoe", {31'd0, dqOeB}, 32'd1);
      dataB = 32'h55667788;
      maskB = 4'b0000;
      applyStimulus();
      checkOutput("B_d1_word", {dqD0B, dqD1B}, 32'h55667788);
      checkOutput("B_d1_ack",  {31'd0, wrAckB}, 32'd0);
      applyStimulus();
      checkOutput("B_post_oe", {30'd0, dqOeB, dqsOeB}, 32'd1);
      checkOutput("B_post_dm", {28'd0, dmD0B, dmD1B}, 32'hF);
      applyStimulus();
      checkOutput("B_idle_busy", {31'd0, busyB}, 32'd0);

      // Mid-burst reset: rst_n low on the edge ending the second DATA cycle.
      startA = 1'b1;
      applyStimulus();
      startA = 1'b0;
      dataA  = 32'h12345678;
      maskA  = 4'b0000;
      applyStimulus();
      checkOutput("mr_d0", {dqD0A, dqD1A}, 32'h12345678);
      dataA = 32'h9ABCDEF0;
      applyStimulus();
      checkOutput("mr_d1", {dqD0A, dqD1A}, 32'h9ABCDEF0);
      rstN = 1'b0;
      applyStimulus();
      checkOutput("mr_oe",   {30'd0, dqOeA, dqsOeA}, 32'd0);
      checkOutput("mr_busy", {31'd0, busyA}, 32'd0);
      checkOutput("mr_ack",  {31'd0, wrAckA}, 32'd0);
      checkOutput("mr_dm",   {28'd0, dmD0A, dmD1A}, 32'hF);
      rstN = 1'b1;
      applyStimulus();
      checkOutput("mr_idle_busy", {31'd0, busyA}, 32'd0);

      // Fresh burst after the aborted one, different masking.
      maskTab = '{4'b1111, 4'b0000, 4'b0100, 4'b0000};
      expDm0  = '{2'b11, 2'b00, 2'b01, 2'b00};
      expDm1  = '{2'b11, 2'b00, 2'b00, 2'b00};
      burstA(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
